fetch_issue_ctrl: RTL and testbench

FETCH_ISSUE_CTRL -- requirements
Module: fetch_issue_ctrl

---
 rtl/fetch_issue_ctrl_pkg.sv | 9 +
 rtl/fetch_issue_ctrl_instr_queue.sv | 44 ++++
 rtl/fetch_issue_ctrl.sv | 71 +++++++
 tb/tb_fetch_issue_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_issue_ctrl_pkg.sv
// fetch_issue_ctrl_pkg: shared FSM encoding, instruction width and HALT opcode for the fetch/issue front end
package fetch_issue_ctrl_pkg;
  localparam int IW = 16;
  localparam logic [3:0] HALT_OP = 4'hF;
  typedef enum logic [1:0] {S_FETCH, S_FULL, S_HALT} state_t;
  function automatic logic is_halt(input logic [IW-1:0] instr);
    return instr[IW-1 -: 4] == HALT_OP;
  endfunction
endpackage

// File: rtl/fetch_issue_ctrl_instr_queue.sv
// instr_queue: instruction FIFO with occupancy count, negedge-clocked
//   CLK/CLR  clock (negedge) and async active-high reset
//   clr      synchronous empty (redirect)
//   wr/wdata enqueue strobe and word
//   rd       dequeue strobe for the head
//   rdata    head entry (zero when empty)
//   count    number of valid entries, 0..DEPTH
module instr_queue
  import fetch_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = IW,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          clr,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(negedge CLK or posedge CLR)
    if (CLR) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(negedge CLK)
    if (wr && !clr) mem[wp] <= wdata;
  assign rdata = (count != '0) ? mem[rp] : '0;
endmodule

// File: rtl/fetch_issue_ctrl.sv
// fetch_issue_ctrl: instruction fetch sequencer feeding an issue queue, with HALT stop and flush redirect
//   CLK/CLR           clock (all state on negedge) and async active-high reset
//   memAddr/memRd     instruction-memory read request
//   memData           instruction returned the cycle after memRd
//   rsReady           reservation station accepts the head this cycle
//   flush/flushPC     redirect: empty queue, drop in-flight word, restart at flushPC
//   issueValid/IRin   head valid / instruction-register load (dequeue)
//   instrOut          head instruction
//   halted            fetch stopped by an issued HALT
module fetch_issue_ctrl
  import fetch_issue_ctrl_pkg::*;
#(
  parameter int PCW = 8,
  parameter int QDEPTH = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic           CLK,
  input  logic           CLR,
  output logic [PCW-1:0] memAddr,
  output logic           memRd,
  input  logic [IW-1:0]  memData,
  input  logic           rsReady,
  input  logic           flush,
  input  logic [PCW-1:0] flushPC,
  output logic           issueValid,
  output logic           IRin,
  output logic [IW-1:0]  instrOut,
  output logic           halted
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t state, state_n;
  logic [PCW-1:0] pc;
  logic inflight, space, enq, halt_hit;
  logic [CW-1:0] count, cnt_n;
  instr_queue #(.DEPTH(QDEPTH), .W(IW)) u_q (
    .CLK(CLK),
    .CLR(CLR),
    .clr(flush),
    .wr(enq),
    .wdata(memData),
    .rd(IRin),
    .rdata(instrOut),
    .count(count)
  );
  // an in-flight word already owns a slot, so requests never overrun the queue
  assign space = (count + CW'(inflight)) < CW'(QDEPTH);
  // the flush cycle issues no request; the redirected fetch starts one cycle later
  assign memRd = ~CLR & ~flush & (state == S_FETCH) & space;
  assign memAddr = pc;
  assign issueValid = count != '0;
  assign IRin = issueValid & rsReady & ~flush;
  assign enq = inflight & ~flush;
  assign halt_hit = IRin & is_halt(instrOut);
  assign halted = state == S_HALT;
  always_comb begin
    cnt_n = count + CW'(enq) - CW'(IRin);
    state_n = flush ? S_FETCH :
              (halt_hit || state == S_HALT) ? S_HALT :
              (cnt_n + CW'(memRd) == CW'(QDEPTH)) ? S_FULL : S_FETCH;
  end
  always_ff @(negedge CLK or posedge CLR)
    if (CLR) begin
      state <= S_FETCH;
      pc <= PCW'(RESET_PC);
      inflight <= 1'b0;
    end else begin
      state <= state_n;
      pc <= flush ? flushPC : pc + PCW'(memRd);
      inflight <= memRd;
    end
endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// tb_fetch_issue_ctrl: randomized and directed check of fetch_issue_ctrl against a queue-based reference model
module tb_fetch_issue_ctrl;
  localparam int QD = 4;
  logic CLK = 1'b0;
  logic CLR, memRd, rsReady, flush, issueValid, IRin, halted;
  logic [7:0] memAddr, flushPC;
  logic [15:0] memData, instrOut;
  fetch_issue_ctrl #(.PCW(8), .QDEPTH(QD), .RESET_PC(0)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .memAddr(memAddr),
    .memRd(memRd),
    .memData(memData),
    .rsReady(rsReady),
    .flush(flush),
    .flushPC(flushPC),
    .issueValid(issueValid),
    .IRin(IRin),
    .instrOut(instrOut),
    .halted(halted)
  );
  always #5 CLK = ~CLK;
  logic [15:0] mem [256];
  logic [15:0] q[$];
  logic [7:0] pc, pend_a, rsp_a;
  bit pend, hlt, rsp_v;
  int checks, errors;
  logic o_rd, o_irin, o_valid, o_halt;
  logic [7:0] o_addr;
  logic [15:0] o_instr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit rs, input bit fl = 0, input logic [7:0] fpc = 0, input bit cl = 0);
    logic e_rd, e_irin, e_valid;
    logic [15:0] e_instr, popped;
    @(posedge CLK);
    #1;
    memData = rsp_v ? mem[rsp_a] : 16'($urandom);
    rsReady = rs;
    flush = fl;
    flushPC = fpc;
    CLR = cl;
    if (cl) begin
      q.delete();
      pc = 8'h00;
      pend = 0;
      hlt = 0;
    end
    #1;
    e_valid = q.size() != 0;
    e_instr = e_valid ? q[0] : 16'h0000;
    e_irin = e_valid && rs && !fl;
    e_rd = !cl && !fl && !hlt && (q.size() + int'(pend) < QD);
    chk("memRd", memRd, e_rd);
    chk("memAddr", memAddr, pc);
    chk("issueValid", issueValid, e_valid);
    chk("IRin", IRin, e_irin);
    chk("instrOut", instrOut, e_instr);
    chk("halted", halted, hlt);
    o_rd = memRd;
    o_addr = memAddr;
    o_valid = issueValid;
    o_irin = IRin;
    o_instr = instrOut;
    o_halt = halted;
    rsp_v = e_rd;
    rsp_a = pc;
    @(negedge CLK);
    if (fl && !cl) begin
      q.delete();
      pc = fpc;
      pend = 0;
      hlt = 0;
    end else if (!cl) begin
      if (e_irin) begin
        popped = q.pop_front();
        if (popped[15:12] == 4'hF) hlt = 1;
      end
      if (pend) q.push_back(mem[pend_a]);
      pend = e_rd;
      pend_a = pc;
      if (e_rd) pc++;
    end
  endtask
  initial begin
    int n;
    bit stale;
    CLR = 1'b1;
    rsReady = 0;
    flush = 0;
    flushPC = 0;
    memData = 0;
    rsp_v = 0;
    pend = 0;
    hlt = 0;
    pc = 0;
    pend_a = 0;
    rsp_a = 0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hEFFF));
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[3] = 16'hBEEF;
    for (int i = 4; i < 256; i++) if (mem[i] == 16'hBEEF) mem[i] = 16'h0BEE;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("rst_instr", o_instr, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1);
      if (i == 0) chk("first_addr", {o_rd, o_addr}, {1'b1, 8'h00});
      if (i == 2) chk("issue0", {o_irin, o_instr}, {1'b1, 16'h1234});
      if (i == 3) chk("issue1", {o_irin, o_instr}, {1'b1, 16'h5678});
    end
    cycle(0, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0);
      n += int'(o_rd);
    end
    chk("req_count", n, 4);
    cycle(1);
    cycle(1);
    chk("resume", {o_rd, o_addr}, {1'b1, 8'h04});
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0);
    cycle(0, 1, 8'h40);
    cycle(1);
    chk("flush_valid", o_valid, 0);
    chk("flush_addr", {o_rd, o_addr}, {1'b1, 8'h40});
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      if (o_irin && o_instr == 16'hBEEF) stale = 1;
    end
    chk("stale_issue", stale, 0);
    mem[2] = 16'hF000;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle(1);
    chk("halt_state", {o_halt, o_rd}, {1'b1, 1'b0});
    cycle(1, 1, 8'h10);
    cycle(1);
    chk("unhalt", {o_halt, o_rd, o_addr}, {1'b0, 1'b1, 8'h10});
    mem[2] = 16'h0002;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0);
    chk("pre_clr_valid", o_valid, 1);
    cycle(0, 0, 0, 1);
    chk("clr_outs", {o_rd, o_addr, o_valid, o_irin, o_instr, o_halt}, 28'h0);
    cycle(1);
    chk("clr_first", {o_rd, o_addr}, {1'b1, 8'h00});
    cycle(1, 1, 8'hFF);
    cycle(1);
    chk("wrap_ff", {o_rd, o_addr}, {1'b1, 8'hFF});
    cycle(1);
    chk("wrap_00", {o_rd, o_addr}, {1'b1, 8'h00});
    for (int i = 0; i < 12; i++) mem[$urandom_range(0, 255)] = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, 8'($urandom), $urandom_range(0, 59) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
